// File: rtl/fifo_master_if.sv
// fifo_master_if: bundle of the command/response and FIFO-side signals of fifo_master.
//   Command side : cmd_valid, cmd_ready, cmd_op, cmd_len, cmd_wdata
//   FIFO side    : f_op_clear, f_wr_en, f_rd_en, f_din, f_wr_ack, f_wr_err,
//                  f_rd_ack, f_rd_err, f_dout
//   Result side  : rd_valid, rd_data, done, status, xfer_cnt
// Modports: master (the fifo_master itself), slave (host + FIFO environment).
interface fifo_master_if #(
    parameter int unsigned DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [3:0]        cmd_len;
    logic [DATA_W-1:0] cmd_wdata;

    logic              f_op_clear;
    logic              f_wr_en;
    logic              f_rd_en;
    logic [DATA_W-1:0] f_din;
    logic              f_wr_ack;
    logic              f_wr_err;
    logic              f_rd_ack;
    logic              f_rd_err;
    logic [DATA_W-1:0] f_dout;

    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              done;
    logic [1:0]        status;
    logic [3:0]        xfer_cnt;

    modport master (
        input  cmd_valid, cmd_op, cmd_len, cmd_wdata,
        input  f_wr_ack, f_wr_err, f_rd_ack, f_rd_err, f_dout,
        output cmd_ready, f_op_clear, f_wr_en, f_rd_en, f_din,
        output rd_valid, rd_data, done, status, xfer_cnt
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_len, cmd_wdata,
        output f_wr_ack, f_wr_err, f_rd_ack, f_rd_err, f_dout,
        input  cmd_ready, f_op_clear, f_wr_en, f_rd_en, f_din,
        input  rd_valid, rd_data, done, status, xfer_cnt
    );
endinterface

// File: rtl/fifo_master.sv
// fifo_master: command-driven initiator for an 8-deep FIFO.
//   Accepts one command (CLEAR, WRITE burst, READ burst), drives one FIFO request per
//   cycle, stops a burst on the first FIFO error and reports status/xfer_cnt on done.
// Ports:
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset
//   fifo_io  : fifo_master_if.master (command, FIFO request/response, result signals)
// Optional feature macro: FIFO_MASTER_CHECK_EN -- READ data is compared against
//   cmd_wdata+k; a mismatch reports status 11 unless a FIFO error occurred.
module fifo_master #(
    parameter int unsigned DATA_W = 32
) (
    input logic           clk,
    input logic           reset_n,
    fifo_master_if.master fifo_io
);

    typedef enum logic [2:0] {StIdle, StClr, StIssue, StDrain, StDone} state_e;

    localparam logic [1:0] OpClear = 2'b00;
    localparam logic [1:0] OpWrite = 2'b01;
    localparam logic [1:0] OpRead  = 2'b10;

    state_e            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [3:0]        len_q, len_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic [3:0]        issued_q, issued_d;
    logic [3:0]        acc_q, acc_d;
    logic              err_seen_q, err_seen_d;
    logic [1:0]        err_kind_q, err_kind_d;
    logic              resp_exp_q, resp_exp_d;

    logic              cmd_ready_q, cmd_ready_d;
    logic              f_op_clear_q, f_op_clear_d;
    logic              f_wr_en_q, f_wr_en_d;
    logic              f_rd_en_q, f_rd_en_d;
    logic [DATA_W-1:0] f_din_q, f_din_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              done_q, done_d;
    logic [1:0]        status_q, status_d;
    logic [3:0]        xfer_cnt_q, xfer_cnt_d;

    logic              is_write;
    logic              ack_in;
    logic              err_in;
    logic              take;
    logic [3:0]        acc_next;
    logic              err_seen_next;
    logic [1:0]        err_kind_next;
    logic [1:0]        status_next;

`ifdef FIFO_MASTER_CHECK_EN
    logic              mism_q, mism_d;
    logic              mism_next;
`endif

    // Response decode. A response is only expected in the cycle after a request, so stray
    // ack/err pulses outside a burst are ignored. Responses after the first error are
    // absorbed without counting.
    always_comb begin
        is_write      = (op_q == OpWrite);
        ack_in        = resp_exp_q & (is_write ? fifo_io.f_wr_ack : fifo_io.f_rd_ack);
        err_in        = resp_exp_q & (is_write ? fifo_io.f_wr_err : fifo_io.f_rd_err);
        take          = ack_in & ~err_seen_q;
        acc_next      = acc_q + {3'b000, take};
        err_seen_next = err_seen_q | err_in;
        err_kind_next = err_kind_q;
        if (err_in && !err_seen_q) begin
            err_kind_next = is_write ? 2'b01 : 2'b10;
        end
`ifdef FIFO_MASTER_CHECK_EN
        // Acks arrive in order, so acc_q is the index of the word being acked.
        mism_next = mism_q |
                    (take & ~is_write & (fifo_io.f_dout != (seed_q + DATA_W'(acc_q))));
        status_next = err_seen_next ? err_kind_next : (mism_next ? 2'b11 : 2'b00);
`else
        status_next = err_seen_next ? err_kind_next : 2'b00;
`endif
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        len_d        = len_q;
        seed_d       = seed_q;
        issued_d     = issued_q;
        acc_d        = acc_next;
        err_seen_d   = err_seen_next;
        err_kind_d   = err_kind_next;
        resp_exp_d   = f_wr_en_q | f_rd_en_q;
        f_op_clear_d = 1'b0;
        f_wr_en_d    = 1'b0;
        f_rd_en_d    = 1'b0;
        f_din_d      = f_din_q;
        rd_valid_d   = take & ~is_write;
        rd_data_d    = (take & ~is_write) ? fifo_io.f_dout : rd_data_q;
        done_d       = 1'b0;
        status_d     = status_q;
        xfer_cnt_d   = xfer_cnt_q;
`ifdef FIFO_MASTER_CHECK_EN
        mism_d       = mism_next;
`endif

        case (state_q)
            StIdle: begin
                if (fifo_io.cmd_valid && cmd_ready_q) begin
                    op_d       = fifo_io.cmd_op;
                    len_d      = fifo_io.cmd_len;
                    seed_d     = fifo_io.cmd_wdata;
                    issued_d   = 4'd0;
                    acc_d      = 4'd0;
                    err_seen_d = 1'b0;
                    err_kind_d = 2'b00;
`ifdef FIFO_MASTER_CHECK_EN
                    mism_d     = 1'b0;
`endif
                    if (fifo_io.cmd_op == OpClear) begin
                        state_d      = StClr;
                        f_op_clear_d = 1'b1;
                    end else if ((fifo_io.cmd_op == OpWrite || fifo_io.cmd_op == OpRead) &&
                                 fifo_io.cmd_len != 4'd0) begin
                        state_d  = StIssue;
                        issued_d = 4'd1;
                        if (fifo_io.cmd_op == OpWrite) begin
                            f_wr_en_d = 1'b1;
                            f_din_d   = fifo_io.cmd_wdata;
                        end else begin
                            f_rd_en_d = 1'b1;
                        end
                    end else begin
                        // Zero-length burst or reserved op: complete without FIFO traffic.
                        state_d    = StDone;
                        done_d     = 1'b1;
                        status_d   = 2'b00;
                        xfer_cnt_d = 4'd0;
                    end
                end
            end
            StClr: begin
                state_d    = StDone;
                done_d     = 1'b1;
                status_d   = 2'b00;
                xfer_cnt_d = 4'd0;
            end
            StIssue: begin
                if (err_in || issued_q == len_q) begin
                    state_d = StDrain;
                end else begin
                    issued_d = issued_q + 4'd1;
                    if (is_write) begin
                        f_wr_en_d = 1'b1;
                        f_din_d   = seed_q + DATA_W'(issued_q);
                    end else begin
                        f_rd_en_d = 1'b1;
                    end
                end
            end
            StDrain: begin
                // Enables are already low here; the response seen this cycle is the last.
                if (!f_wr_en_q && !f_rd_en_q) begin
                    state_d    = StDone;
                    done_d     = 1'b1;
                    status_d   = status_next;
                    xfer_cnt_d = acc_next;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        cmd_ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            op_q         <= 2'b00;
            len_q        <= 4'd0;
            seed_q       <= '0;
            issued_q     <= 4'd0;
            acc_q        <= 4'd0;
            err_seen_q   <= 1'b0;
            err_kind_q   <= 2'b00;
            resp_exp_q   <= 1'b0;
            cmd_ready_q  <= 1'b1;
            f_op_clear_q <= 1'b0;
            f_wr_en_q    <= 1'b0;
            f_rd_en_q    <= 1'b0;
            f_din_q      <= '0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            done_q       <= 1'b0;
            status_q     <= 2'b00;
            xfer_cnt_q   <= 4'd0;
`ifdef FIFO_MASTER_CHECK_EN
            mism_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            len_q        <= len_d;
            seed_q       <= seed_d;
            issued_q     <= issued_d;
            acc_q        <= acc_d;
            err_seen_q   <= err_seen_d;
            err_kind_q   <= err_kind_d;
            resp_exp_q   <= resp_exp_d;
            cmd_ready_q  <= cmd_ready_d;
            f_op_clear_q <= f_op_clear_d;
            f_wr_en_q    <= f_wr_en_d;
            f_rd_en_q    <= f_rd_en_d;
            f_din_q      <= f_din_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            done_q       <= done_d;
            status_q     <= status_d;
            xfer_cnt_q   <= xfer_cnt_d;
`ifdef FIFO_MASTER_CHECK_EN
            mism_q       <= mism_d;
`endif
        end
    end

    assign fifo_io.cmd_ready  = cmd_ready_q;
    assign fifo_io.f_op_clear = f_op_clear_q;
    assign fifo_io.f_wr_en    = f_wr_en_q;
    assign fifo_io.f_rd_en    = f_rd_en_q;
    assign fifo_io.f_din      = f_din_q;
    assign fifo_io.rd_valid   = rd_valid_q;
    assign fifo_io.rd_data    = rd_data_q;
    assign fifo_io.done       = done_q;
    assign fifo_io.status     = status_q;
    assign fifo_io.xfer_cnt   = xfer_cnt_q;

endmodule

// File: tb/tb_fifo_master.sv
// tb_fifo_master: table-driven bench for fifo_master with an 8-deep FIFO model and
// scoreboard queues for expected f_din and rd_data values.
module tb_fifo_master;

`ifdef FIFO_MASTER_CHECK_EN
    localparam bit Chk = 1'b1;
`else
    localparam bit Chk = 1'b0;
`endif

    logic clk;
    logic reset_n;

    fifo_master_if #(.DATA_W(32)) bus ();

    fifo_master #(.DATA_W(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .fifo_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] wr_exp[$];
    logic [31:0] rd_exp[$];
    logic [31:0] ref_fifo[$];
    logic [31:0] fmem[$];
    int clr_cnt = 0;
    int rd_cnt  = 0;
    int done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // FIFO model: 8 deep, response one cycle after the request, not affected by reset_n.
    always @(posedge clk) begin
        bus.f_wr_ack <= 1'b0;
        bus.f_wr_err <= 1'b0;
        bus.f_rd_ack <= 1'b0;
        bus.f_rd_err <= 1'b0;
        if (bus.f_op_clear) begin
            fmem.delete();
        end else if (bus.f_wr_en) begin
            if (fmem.size() < 8) begin
                fmem.push_back(bus.f_din);
                bus.f_wr_ack <= 1'b1;
            end else begin
                bus.f_wr_err <= 1'b1;
            end
        end else if (bus.f_rd_en) begin
            if (fmem.size() > 0) begin
                bus.f_dout   <= fmem.pop_front();
                bus.f_rd_ack <= 1'b1;
            end else begin
                bus.f_rd_err <= 1'b1;
            end
        end
    end

    // Monitor: scoreboard pops and request-exclusivity checks.
    always @(negedge clk) begin
        if (bus.f_wr_en) begin
            if (wr_exp.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: f_din 0x%0h, required no write", bus.f_din);
            end else begin
                check("f_din", bus.f_din, wr_exp.pop_front());
            end
        end
        if (bus.rd_valid) begin
            if (rd_exp.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_rd_valid: rd_data 0x%0h, required none", bus.rd_data);
            end else begin
                check("rd_data", bus.rd_data, rd_exp.pop_front());
            end
        end
        if ((bus.f_wr_en && bus.f_rd_en) || (bus.f_op_clear && (bus.f_wr_en || bus.f_rd_en)))
        begin
            n_vec++;
            n_err++;
            $display("FAIL req_exclusive: clr=%0b wr=%0b rd=%0b, required at most one",
                     bus.f_op_clear, bus.f_wr_en, bus.f_rd_en);
        end
        if (bus.f_op_clear) clr_cnt++;
        if (bus.f_rd_en) rd_cnt++;
        if (bus.done) done_cnt++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  len;
        logic [31:0] seed;
        logic [1:0]  st;
        logic [3:0]  xfer;
        int          n_issue;
        int          n_clear;
    } vec_t;

    vec_t vecs[12];

    task automatic run_vec(input vec_t v, input int idx);
        bit ok;
        clr_cnt = 0;
        rd_cnt  = 0;
        if (v.op == 2'b00) begin
            ref_fifo.delete();
        end else if (v.op == 2'b01) begin
            for (int k = 0; k < v.n_issue; k++) wr_exp.push_back(v.seed + 32'(k));
            for (int k = 0; k < int'(v.xfer); k++) ref_fifo.push_back(v.seed + 32'(k));
        end else if (v.op == 2'b10) begin
            for (int k = 0; k < int'(v.xfer); k++) rd_exp.push_back(ref_fifo.pop_front());
        end
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = v.op;
        bus.cmd_len   = v.len;
        bus.cmd_wdata = v.seed;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (bus.cmd_ready) ok = 1'b1;
            else @(negedge clk);
        end
        check($sformatf("v%0d_cmd_ready", idx), {31'd0, ok}, 32'd1);
        @(posedge clk);
        #1;
        // Keep requesting a CLEAR while busy; it must be ignored.
        bus.cmd_op = 2'b00;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (bus.done) ok = 1'b1;
        end
        bus.cmd_valid = 1'b0;
        check($sformatf("v%0d_done_seen", idx), {31'd0, ok}, 32'd1);
        check($sformatf("v%0d_status", idx), {30'd0, bus.status}, {30'd0, v.st});
        check($sformatf("v%0d_xfer_cnt", idx), {28'd0, bus.xfer_cnt}, {28'd0, v.xfer});
        @(negedge clk);
        check($sformatf("v%0d_clear_cycles", idx), 32'(clr_cnt), 32'(v.n_clear));
        check($sformatf("v%0d_read_reqs", idx), 32'(rd_cnt),
              (v.op == 2'b10) ? 32'(v.n_issue) : 32'd0);
        check($sformatf("v%0d_wr_left", idx), 32'(wr_exp.size()), 32'd0);
        check($sformatf("v%0d_rd_left", idx), 32'(rd_exp.size()), 32'd0);
        check($sformatf("v%0d_idle_ready", idx), {31'd0, bus.cmd_ready}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, {31'd0, bus.cmd_ready}, 32'd1);
        check({tag, "_enables"}, {29'd0, bus.f_op_clear, bus.f_wr_en, bus.f_rd_en}, 32'd0);
        check({tag, "_f_din"}, bus.f_din, 32'd0);
        check({tag, "_rd_data"}, bus.rd_data, 32'd0);
        check({tag, "_flags"}, {24'd0, bus.rd_valid, bus.done, bus.status, bus.xfer_cnt},
              32'd0);
    endtask

    initial begin
        int n_ack;
        int done0;
        bit hit;
        //            op     len    seed          st                   xfer  iss clr
        vecs[0]  = '{2'b00, 4'd0,  32'h0,        2'b00,               4'd0, 0,  1};
        vecs[1]  = '{2'b01, 4'd5,  32'h10,       2'b00,               4'd5, 5,  0};
        vecs[2]  = '{2'b01, 4'd8,  32'h20,       2'b01,               4'd3, 5,  0};
        vecs[3]  = '{2'b10, 4'd9,  32'h10,       2'b10,               4'd8, 9,  0};
        vecs[4]  = '{2'b01, 4'd2,  32'h5,        2'b00,               4'd2, 2,  0};
        vecs[5]  = '{2'b10, 4'd2,  32'h6,        Chk ? 2'b11 : 2'b00, 4'd2, 2,  0};
        vecs[6]  = '{2'b01, 4'd0,  32'h77,       2'b00,               4'd0, 0,  0};
        vecs[7]  = '{2'b11, 4'd3,  32'h0,        2'b00,               4'd0, 0,  0};
        vecs[8]  = '{2'b10, 4'd3,  32'h0,        2'b10,               4'd0, 2,  0};
        vecs[9]  = '{2'b01, 4'd15, 32'hFFFFFFFE, 2'b01,               4'd8, 10, 0};
        vecs[10] = '{2'b00, 4'd0,  32'h0,        2'b00,               4'd0, 0,  1};
        vecs[11] = '{2'b10, 4'd1,  32'h0,        2'b10,               4'd0, 1,  0};

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_len   = 4'd0;
        bus.cmd_wdata = 32'd0;
        reset_n = 1'b0;
        #23;
        check_reset_outputs("rst0");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst0_release_ready", {31'd0, bus.cmd_ready}, 32'd1);

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // Reset while idle with non-zero result registers.
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #2;
        check_reset_outputs("rst_idle");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_idle_release_ready", {31'd0, bus.cmd_ready}, 32'd1);

        // Reset in the middle of a WRITE burst after two acks.
        for (int k = 0; k < 3; k++) wr_exp.push_back(32'h100 + 32'(k));
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b01;
        bus.cmd_len   = 4'd10;
        bus.cmd_wdata = 32'h100;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        n_ack = 0;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            if (bus.f_wr_ack) n_ack++;
            if (n_ack == 2) hit = 1'b1;
        end
        check("mid_two_acks", {31'd0, hit}, 32'd1);
        done0 = done_cnt;
        #1 reset_n = 1'b0;
        #1;
        check("mid_wr_en_low", {30'd0, bus.f_wr_en, bus.f_rd_en}, 32'd0);
        check("mid_ready", {31'd0, bus.cmd_ready}, 32'd1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check("mid_no_done", 32'(done_cnt), 32'(done0));
        check("mid_release_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("mid_wr_left", 32'(wr_exp.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
